// File: rtl/multiword_add_sequencer.sv
// -----------------------------------------------------------------------------
// multiword_add_sequencer
//
// Multi-precision add controller for an external WIDTH-bit adder stage. It
// accepts two NUM_WORDS*WIDTH-bit operands and a carry-in, then feeds the
// adder one slice per step, least-significant slice first. Each slice's carry
// out becomes the next slice's carry in. The sum slices are collected into
// `result`, and the final carry is presented on `result_cout`.
//
// Parameters
//   WIDTH          slice width; must match the attached adder
//   NUM_WORDS      number of slices per operand (>= 1)
//   ADDER_LATENCY  0 = combinational adder, 1 = registered adder
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake (op_a, op_b, op_cin)
//   add_a/add_b/add_cin      slice operands driven to the adder
//   add_sum/add_cout         adder response
//   out_valid/out_ready      result handshake (result, result_cout)
//   busy                     high whenever an operation is in progress
// -----------------------------------------------------------------------------
module multiword_add_sequencer #(
    parameter int WIDTH         = 4,
    parameter int NUM_WORDS     = 4,
    parameter int ADDER_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH*NUM_WORDS-1:0] op_a,
    input  logic [WIDTH*NUM_WORDS-1:0] op_b,
    input  logic                       op_cin,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    output logic                       add_cin,
    input  logic [WIDTH-1:0]           add_sum,
    input  logic                       add_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH*NUM_WORDS-1:0] result,
    output logic                       result_cout,
    output logic                       busy
);

    localparam int TOTAL = WIDTH * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // WAIT gives a registered adder one cycle to produce its sum. It is
    // unreachable when ADDER_LATENCY is 0.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [TOTAL-1:0] a_reg;
    logic [TOTAL-1:0] b_reg;
    logic             carry;
    logic [IDX_W-1:0] index;

    logic             accept;
    logic             capture;
    logic             last_slice;

    assign last_slice = (index == LAST_IDX);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first. Without the
        // defaults, a path that skips an assignment would infer a latch.
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                add_a   = a_reg[int'(index) * WIDTH +: WIDTH];
                add_b   = b_reg[int'(index) * WIDTH +: WIDTH];
                add_cin = carry;
                if (ADDER_LATENCY == 0) begin
                    // A combinational adder answers within the same cycle.
                    capture    = 1'b1;
                    next_state = last_slice ? DONE : ISSUE;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                // Hold the adder inputs stable while its registered sum settles.
                add_a      = a_reg[int'(index) * WIDTH +: WIDTH];
                add_b      = b_reg[int'(index) * WIDTH +: WIDTH];
                add_cin    = carry;
                capture    = 1'b1;
                next_state = last_slice ? DONE : ISSUE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every datapath register is explicitly reset. This keeps a
    // discarded operation from leaking stale operands or partial sums into
    // the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            carry       <= 1'b0;
            index       <= '0;
            result      <= '0;
            result_cout <= 1'b0;
        end else if (accept) begin
            // The operands are frozen here. Later changes on op_a/op_b are ignored.
            a_reg <= op_a;
            b_reg <= op_b;
            carry <= op_cin;
            index <= '0;
        end else if (capture) begin
            result[int'(index) * WIDTH +: WIDTH] <= add_sum;
            carry                                <= add_cout;
            if (last_slice) begin
                // The index parks on the last slice until the next accept.
                result_cout <= add_cout;
            end else begin
                index <= index + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for multiword_add_sequencer.
// The main instance uses the default parameters with a registered adder. It
// runs directed and randomized operations and is checked by a scoreboard: an
// accept monitor pushes the arithmetically expected sum, and a result monitor
// pops and compares it.
// A second instance uses a combinational adder (ADDER_LATENCY = 0) and is
// exercised with a short directed sequence.
// -----------------------------------------------------------------------------
module tb_multiword_add_sequencer;

    localparam int W     = 4;
    localparam int N     = 4;
    localparam int TOT   = W * N;
    localparam int LAT   = N * 2;
    localparam int LAT_Z = N;

    typedef struct {
        logic [TOT:0] val;
        int           cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;

    // Main instance: registered adder.
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [TOT-1:0] op_a = '0;
    logic [TOT-1:0] op_b = '0;
    logic           op_cin = 1'b0;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_cout;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [TOT-1:0] result;
    logic           result_cout;
    logic           busy;

    // Second instance: combinational adder.
    logic           in_valid_z = 1'b0;
    logic           in_ready_z;
    logic [TOT-1:0] op_a_z = '0;
    logic [TOT-1:0] op_b_z = '0;
    logic           op_cin_z = 1'b0;
    logic [W-1:0]   add_a_z, add_b_z, add_sum_z;
    logic           add_cin_z, add_cout_z;
    logic           out_valid_z;
    logic           out_ready_z = 1'b1;
    logic [TOT-1:0] result_z;
    logic           result_cout_z;
    logic           busy_z;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_results = 0;
    int   hs_cyc = 0;
    int   acc_cyc_last = 0;
    bit   ripple_chk = 1'b0;
    bit   prev_ov = 1'b0;
    logic [TOT:0] held = '0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiword_add_sequencer #(.WIDTH(W), .NUM_WORDS(N), .ADDER_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_cout(result_cout), .busy(busy)
    );

    // Registered adder stage: the sum appears one cycle after its inputs.
    always @(posedge clk)
        {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    multiword_add_sequencer #(.WIDTH(W), .NUM_WORDS(N), .ADDER_LATENCY(0)) u_dut_z (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_z), .in_ready(in_ready_z),
        .op_a(op_a_z), .op_b(op_b_z), .op_cin(op_cin_z),
        .add_a(add_a_z), .add_b(add_b_z), .add_cin(add_cin_z),
        .add_sum(add_sum_z), .add_cout(add_cout_z),
        .out_valid(out_valid_z), .out_ready(out_ready_z),
        .result(result_z), .result_cout(result_cout_z), .busy(busy_z)
    );

    assign {add_cout_z, add_sum_z} = {1'b0, add_a_z} + {1'b0, add_b_z} + {{W{1'b0}}, add_cin_z};

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic logic [TOT:0] model(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{TOT{1'b0}}, c};
    endfunction

    // Scoreboard: both monitors sample at the falling edge, away from the
    // active edge. Inputs are only driven just after rising edges.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back('{val: model(op_a, op_b, op_cin), cyc: cyc + 1});
                acc_cyc_last = cyc + 1;
            end
            if (ripple_chk && busy && !out_valid)
                check("ripple_add_cin", add_cin, 1'b1);
            if (out_valid) begin
                check("in_ready_in_done", in_ready, 1'b0);
                if (!prev_ov) begin
                    if (exp_q.size() == 0) begin
                        timeout_fail("unexpected_result");
                    end else begin
                        check("latency", cyc - exp_q[0].cyc, LAT);
                        check("result", {result_cout, result}, exp_q[0].val);
                    end
                    held = {result_cout, result};
                end else begin
                    check("result_stable", {result_cout, result}, held);
                end
                if (out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs_cyc = cyc + 1;
                    n_results++;
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic c);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) timeout_fail("wait_in_ready");
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = c;
        tick();
        in_valid = 1'b0;
        op_a     = TOT'($urandom);
        op_b     = TOT'($urandom);
        op_cin   = 1'($urandom);
    endtask

    task automatic wait_results(input int target, input bit rand_ready);
        int n = 0;
        while (n_results < target && n < 500) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        if (n_results < target) timeout_fail("wait_result");
    endtask

    // Directed run on the combinational-adder instance. Each slice must be
    // issued in consecutive cycles with no wait cycle in between.
    task automatic run_z(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic c);
        logic [TOT:0] e;
        logic [TOT:0] lo;
        e           = model(a, b, c);
        in_valid_z  = 1'b1;
        op_a_z      = a;
        op_b_z      = b;
        op_cin_z    = c;
        tick();
        in_valid_z  = 1'b0;
        op_a_z      = TOT'($urandom);
        for (int k = 0; k < N; k++) begin
            lo = model(a & TOT'((1 << (W * k)) - 1), b & TOT'((1 << (W * k)) - 1), c);
            check("z_add_a", add_a_z, (a >> (W * k)) & TOT'((1 << W) - 1));
            check("z_add_cin", add_cin_z, lo[W * k]);
            check("z_not_valid_yet", out_valid_z, 1'b0);
            tick();
        end
        check("z_out_valid", out_valid_z, 1'b1);
        check("z_result", {result_cout_z, result_z}, e);
        tick();
        check("z_back_to_idle", in_ready_z, 1'b1);
    endtask

    initial begin
        logic [TOT-1:0] a2, b2;
        int base;

        // Reset state.
        rst = 1'b1;
        repeat (2) tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", {result_cout, result}, '0);
        check("rst_add_ops", {add_a, add_b, add_cin}, '0);
        rst = 1'b0;
        tick();

        // Simple carry across a slice boundary.
        do_op(16'h00FF, 16'h0001, 1'b0);
        wait_results(1, 1'b0);
        check("dir_00ff", {result_cout, result}, 17'h00100);

        // Full ripple, with carry-in high on every slice issue.
        ripple_chk = 1'b1;
        do_op(16'hFFFF, 16'h0000, 1'b1);
        wait_results(2, 1'b0);
        ripple_chk = 1'b0;
        check("dir_ripple", {result_cout, result}, 17'h10000);

        // Backpressure: hold DONE while the operand inputs change.
        out_ready = 1'b0;
        do_op(TOT'($urandom), TOT'($urandom), 1'($urandom));
        base = 0;
        while (!out_valid && base < 50) begin
            tick();
            base++;
        end
        if (!out_valid) timeout_fail("bp_out_valid");
        for (int i = 0; i < 10; i++) begin
            op_a     = TOT'($urandom);
            in_valid = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("bp_still_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        check("bp_released_valid", out_valid, 1'b0);
        check("bp_released_idle", in_ready, 1'b1);

        // Asynchronous reset while slice 2 is in flight.
        do_op(16'hFFFF, 16'h0001, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_result", {result_cout, result}, '0);
        check("arst_add_ops", {add_a, add_b, add_cin}, '0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        n_results = 0;
        do_op(16'h0003, 16'h0004, 1'b0);
        wait_results(1, 1'b0);
        check("post_rst", {result_cout, result}, 17'h00007);

        // Back-to-back with in_valid held high.
        a2 = TOT'($urandom);
        b2 = TOT'($urandom);
        in_valid = 1'b1;
        op_a     = TOT'($urandom);
        op_b     = TOT'($urandom);
        op_cin   = 1'($urandom);
        tick();
        op_a   = a2;
        op_b   = b2;
        op_cin = 1'b1;
        wait_results(2, 1'b0);
        tick();
        in_valid = 1'b0;
        check("b2b_accept_cycle", acc_cyc_last, hs_cyc + 1);
        wait_results(3, 1'b0);

        // Randomized operations with random consumer stalls.
        for (int i = 0; i < 30; i++) begin
            do_op(TOT'($urandom), TOT'($urandom), 1'($urandom));
            wait_results(4 + i, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        check("queue_drained", exp_q.size(), 0);

        // Combinational adder instance.
        run_z(16'h1234, 16'h4321, 1'b0);
        check("z_dir_5555", {result_cout_z, result_z}, 17'h05555);
        for (int i = 0; i < 3; i++)
            run_z(TOT'($urandom), TOT'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-precision add controller wrapped around the team's parameterized WIDTH-bit adder stage.
- Accepts two NUM_WORDS*WIDTH-bit operands plus a carry-in over a valid/ready handshake.
- Feeds the adder one WIDTH-bit slice per step, LSW first, chaining each cout into the next cin.
- Collects the sum slices and presents the full-width result with final carry over a valid/ready handshake.

Parameters:
- WIDTH, 4, slice width; must equal the attached adder's WIDTH.
- NUM_WORDS, 4, number of slices per operand (>=1).
- ADDER_LATENCY, 1, adder latency in cycles: 0 for a combinational adder, 1 for a registered adder. Other values illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- op_a  input  WIDTH*NUM_WORDS  operand A.
- op_b  input  WIDTH*NUM_WORDS  operand B.
- op_cin  input  1  carry into slice 0.
- add_a  output  WIDTH  slice of A driven to the adder.
- add_b  output  WIDTH  slice of B driven to the adder.
- add_cin  output  1  carry driven to the adder.
- add_sum  input  WIDTH  adder sum.
- add_cout  input  1  adder carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH*NUM_WORDS  assembled sum.
- result_cout  output  1  final carry-out.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, rst high):
  - state = IDLE; slice index = 0; carry register = 0; operand registers = 0.
  - result = 0, result_cout = 0, out_valid = 0, add_a/add_b/add_cin = 0, busy = 0, in_ready = 1.
  - Any in-flight operation is discarded; no partial result is ever presented.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - WAIT is used only when ADDER_LATENCY = 1.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1: register op_a, op_b; set carry = op_cin; set index = 0; go to ISSUE.
- ISSUE:
  - Drive add_a = A[index*WIDTH +: WIDTH], add_b = B[index*WIDTH +: WIDTH], add_cin = carry.
  - ADDER_LATENCY = 0, on the edge ending ISSUE:
    - capture add_sum into result[index*WIDTH +: WIDTH]; carry <= add_cout.
    - If index = NUM_WORDS-1: result_cout <= add_cout; go to DONE.
    - Otherwise increment index and stay in ISSUE.
  - ADDER_LATENCY = 1: go to WAIT.
- WAIT:
  - add_a, add_b, add_cin hold their ISSUE values.
  - On the edge ending WAIT: capture as above, then go to ISSUE (next slice) or DONE (last slice).
- Latency:
  - out_valid rises NUM_WORDS*(1+ADDER_LATENCY) edges after the accepting edge.
  - Defaults: 8 cycles.
- DONE:
  - out_valid = 1; result and result_cout stable.
  - add_a, add_b, add_cin = 0.
  - On an edge with out_ready = 1: go to IDLE, out_valid = 0.
  - in_ready stays 0 throughout DONE, so there is no same-cycle accept; minimum spacing between operations is one IDLE cycle.
- Backpressure: DONE is held indefinitely while out_ready = 0; result must not change.
- in_ready is 0 in ISSUE, WAIT and DONE. in_valid during those states is ignored, and op_a/op_b changes do not affect the result.
- Arithmetic: {result_cout, result} = op_a + op_b + op_cin, modulo 2^(WIDTH*NUM_WORDS+1).
- Wrap-around: the index counter never exceeds NUM_WORDS-1.
- NUM_WORDS = 1: the block degenerates to a single issue, with the same handshakes.
- result keeps its last value after the DONE handshake, until overwritten by the next operation's captures. out_valid is the only qualifier.
- Reset mid-operation (any state): immediate return to the reset values; the next operation starts cleanly.

Test Plan:
- Defaults; A=0x00FF, B=0x0001, cin=0 -> result=0x0100, cout=0; out_valid exactly 8 cycles after accept.
- Defaults; A=0xFFFF, B=0x0000, cin=1 -> full carry ripple across all slices; result=0x0000, cout=1. Check add_cin=1 on every slice issue.
- ADDER_LATENCY=0 with a combinational adder; A=0x1234, B=0x4321, cin=0 -> result=0x5555, cout=0 after 4 cycles. Confirm WAIT is never entered.
- Backpressure: hold out_ready=0 for 10 cycles after DONE.
  - result and out_valid stay stable, in_ready stays 0.
  - Changing op_a in that window has no effect.
  - out_ready=1 -> IDLE next cycle.
- Assert rst during slice 2 of A=0xFFFF, B=0x0001.
  - All outputs return to their reset values asynchronously.
  - The next operation A=0x0003, B=0x0004 yields result=0x0007, cout=0.
- Back-to-back operations with in_valid held high: second operation accepted on the first IDLE edge after the out handshake; both results correct.
